// File: rtl/baccarat_sequencer.sv
// Baccarat round controller: wager intake, deal sequencing, banker third-card rule, settlement.
// Optional TIE_PAYOUT_EN raises the tie-on-tie payout from 2x to 9x the wager.
module baccarat_sequencer #(
  parameter int BAL_W    = 10,
  parameter int INIT_BAL = 100,
  parameter int CNT_W    = 8
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             start,
  input  logic [1:0]       bet_in,
  input  logic [BAL_W-1:0] wager_in,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  output logic             betting,
  output logic             load_wager,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic [1:0]       result,
  output logic [BAL_W-1:0] balance,
  output logic [CNT_W-1:0] rounds,
  output logic             bet_error,
  output logic             game_over
);

  typedef enum logic [3:0] {
    S_BET, S_P1, S_D1, S_P2, S_D2, S_DECIDE, S_P3, S_D3, S_SCORE, S_SETTLE, S_BROKE
  } state_t;

  localparam int WIDE_W = BAL_W + 4;

  state_t           state, state_nxt;
  logic [BAL_W-1:0] wager_r;
  logic [1:0]       bet_r;
  logic             drew;

  logic             bet_valid;
  logic             accept;
  logic             banker_draws;
  logic [WIDE_W-1:0] wide_wager;
  logic [WIDE_W-1:0] payout;
  logic [WIDE_W-1:0] credit_sum;
  logic [BAL_W-1:0]  credit_sat;
  logic [1:0]        score_result;

  assign bet_valid = (bet_in != 2'b00) && (wager_in != '0) && (wager_in <= balance);
  assign accept    = (state == S_BET) && start && bet_valid;

  // Banker rule once the player has taken a third card
  always_comb begin
    banker_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (pcard3 != 4'd8);
      4'd4:             banker_draws = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             banker_draws = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             banker_draws = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  end

  always_comb begin
    score_result = 2'b11;
    if (pscore > dscore)      score_result = 2'b01;
    else if (pscore < dscore) score_result = 2'b10;
  end

  // Payout includes the returned stake; the debit happened at acceptance
  assign wide_wager = {4'b0000, wager_r};
  always_comb begin
    payout = '0;
    if (result == 2'b11) begin
      if (bet_r == 2'b11) begin
`ifdef TIE_PAYOUT_EN
        payout = (wide_wager << 3) + wide_wager;
`else
        payout = wide_wager << 1;
`endif
      end else if (bet_r != 2'b00) begin
        payout = wide_wager;
      end
    end else if (bet_r == result) begin
      payout = wide_wager << 1;
    end
  end

  assign credit_sum = {4'b0000, balance} + payout;
  assign credit_sat = (credit_sum[WIDE_W-1:BAL_W] != 4'b0000) ? {BAL_W{1'b1}}
                                                              : credit_sum[BAL_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_BET:    if (accept) state_nxt = S_P1;
      S_P1:     state_nxt = S_D1;
      S_D1:     state_nxt = S_P2;
      S_P2:     state_nxt = S_D2;
      S_D2:     state_nxt = S_DECIDE;
      S_DECIDE: begin
        if (!drew) begin
          if ((pscore >= 4'd8) || (dscore >= 4'd8)) state_nxt = S_SCORE;
          else if (pscore <= 4'd5)                  state_nxt = S_P3;
          else if (dscore <= 4'd5)                  state_nxt = S_D3;
          else                                      state_nxt = S_SCORE;
        end else begin
          state_nxt = banker_draws ? S_D3 : S_SCORE;
        end
      end
      S_P3:     state_nxt = S_DECIDE;
      S_D3:     state_nxt = S_SCORE;
      S_SCORE:  state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = (credit_sat == '0) ? S_BROKE : S_BET;
      S_BROKE:  state_nxt = S_BROKE;
      default:  state_nxt = S_BET;
    endcase
  end

  always_comb begin
    betting     = (state == S_BET);
    load_wager  = accept;
    bet_error   = (state == S_BET) && start && !bet_valid;
    load_pcard1 = (state == S_P1);
    load_pcard2 = (state == S_P2);
    load_pcard3 = (state == S_P3);
    load_dcard1 = (state == S_D1);
    load_dcard2 = (state == S_D2);
    load_dcard3 = (state == S_D3);
    game_over   = (state == S_BROKE);
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state   <= S_BET;
      balance <= BAL_W'(INIT_BAL);
      rounds  <= '0;
      result  <= 2'b00;
      drew    <= 1'b0;
      wager_r <= '0;
      bet_r   <= 2'b00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wager_r <= wager_in;
        bet_r   <= bet_in;
        balance <= balance - wager_in;
        result  <= 2'b00;
      end
      if (state == S_P3)    drew   <= 1'b1;
      if (state == S_SCORE) result <= score_result;
      if (state == S_SETTLE) begin
        balance <= credit_sat;
        drew    <= 1'b0;
        if (rounds != {CNT_W{1'b1}}) rounds <= rounds + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_baccarat_sequencer.sv
// Directed bench for baccarat_sequencer: scripted rounds with hand-computed balances and results.
module tb_baccarat_sequencer;

  logic       slow_clock = 1'b0;
  logic       resetb, start;
  logic [1:0] bet_in;
  logic [9:0] wager_in;
  logic [3:0] pscore, dscore, pcard3;
  logic       betting, load_wager, load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3, bet_error, game_over;
  logic [1:0] result;
  logic [9:0] balance;
  logic [7:0] rounds;

  int vectors = 0;
  int miscompares = 0;

`ifdef TIE_PAYOUT_EN
  localparam logic [9:0] TIE_BAL = 10'd180;
`else
  localparam logic [9:0] TIE_BAL = 10'd110;
`endif

  baccarat_sequencer #(.BAL_W(10), .INIT_BAL(100), .CNT_W(8)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .start(start), .bet_in(bet_in),
    .wager_in(wager_in), .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .betting(betting), .load_wager(load_wager),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .result(result), .balance(balance), .rounds(rounds),
    .bet_error(bet_error), .game_over(game_over)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic do_reset();
    start  = 1'b0;
    resetb = 1'b0;
    #2;
    resetb = 1'b1;
    #1;
  endtask

  // Places a bet and steps through P1..D2, leaving the DUT in DECIDE
  task automatic accept_and_deal(input logic [1:0] b, input logic [9:0] w, input logic [9:0] exp_bal);
    bet_in = b; wager_in = w; start = 1'b1;
    #1;
    check("load_wager", 16'(load_wager), 16'd1);
    tick();
    start = 1'b0;
    check("p1_strobe", 16'(load_pcard1), 16'd1);
    check("debit", 16'(balance), 16'(exp_bal));
    check("result_cleared", 16'(result), 16'd0);
    tick(); check("d1_strobe", 16'(load_dcard1), 16'd1);
    tick(); check("p2_strobe", 16'(load_pcard2), 16'd1);
    tick(); check("d2_strobe", 16'(load_dcard2), 16'd1);
    tick();
  endtask

  initial begin
    resetb = 1'b0; start = 1'b0; bet_in = 2'b00; wager_in = '0;
    pscore = '0; dscore = '0; pcard3 = '0;
    #12 resetb = 1'b1;
    #1;
    check("rst_betting", 16'(betting), 16'd1);
    check("rst_balance", 16'(balance), 16'd100);
    check("rst_rounds", 16'(rounds), 16'd0);
    check("rst_result", 16'(result), 16'd0);
    check("rst_game_over", 16'(game_over), 16'd0);
    check("rst_bet_error", 16'(bet_error), 16'd0);

    // Player natural 8 vs 3
    pscore = 4'd8; dscore = 4'd3;
    accept_and_deal(2'b01, 10'd10, 10'd90);
    tick();
    check("nat_no_p3", 16'(load_pcard3), 16'd0);
    check("nat_no_d3", 16'(load_dcard3), 16'd0);
    tick(); check("nat_result", 16'(result), 16'd1);
    tick();
    check("nat_balance", 16'(balance), 16'd110);
    check("nat_rounds", 16'(rounds), 16'd1);
    check("nat_betting", 16'(betting), 16'd1);

    // Banker bet, player draws, banker 5 with pcard3=5 draws
    do_reset();
    pscore = 4'd4; dscore = 4'd5; pcard3 = 4'd0;
    accept_and_deal(2'b10, 10'd20, 10'd80);
    tick(); check("b_p3_strobe", 16'(load_pcard3), 16'd1);
    pscore = 4'd6; pcard3 = 4'd5;
    tick(); check("b_decide2", 16'(load_pcard3), 16'd0);
    tick(); check("b_d3_strobe", 16'(load_dcard3), 16'd1);
    dscore = 4'd7;
    tick();
    tick(); check("b_result", 16'(result), 16'd2);
    tick(); check("b_balance", 16'(balance), 16'd120);

    // Second pass dscore=3 and pcard3=8: banker stands
    do_reset();
    pscore = 4'd2; dscore = 4'd3; pcard3 = 4'd8;
    accept_and_deal(2'b01, 10'd10, 10'd90);
    tick(); check("s3_p3_strobe", 16'(load_pcard3), 16'd1);
    pscore = 4'd0;
    tick();
    tick(); check("s3_no_d3", 16'(load_dcard3), 16'd0);
    tick(); check("s3_result", 16'(result), 16'd2);
    tick(); check("s3_balance", 16'(balance), 16'd90);

    // Tie bet on a tie, both standing on 7
    do_reset();
    pscore = 4'd7; dscore = 4'd7;
    accept_and_deal(2'b11, 10'd10, 10'd90);
    tick(); check("tie_no_p3", 16'(load_pcard3), 16'd0);
    tick(); check("tie_result", 16'(result), 16'd3);
    tick(); check("tie_balance", 16'(balance), 16'(TIE_BAL));

    // Player bet on a tie is a push
    do_reset();
    accept_and_deal(2'b01, 10'd10, 10'd90);
    tick(); tick(); tick();
    check("push_balance", 16'(balance), 16'd100);
    check("push_rounds", 16'(rounds), 16'd1);

    // Rejected bets: over balance, no bet type, zero wager
    bet_in = 2'b01; wager_in = 10'd101; start = 1'b1;
    #1;
    check("err_over_pulse", 16'(bet_error), 16'd1);
    check("err_over_nowager", 16'(load_wager), 16'd0);
    tick(); check("err_over_stay", 16'(betting), 16'd1);
    bet_in = 2'b00; wager_in = 10'd10;
    #1; check("err_none_pulse", 16'(bet_error), 16'd1);
    tick(); check("err_none_stay", 16'(betting), 16'd1);
    bet_in = 2'b01; wager_in = 10'd0;
    #1; check("err_zero_pulse", 16'(bet_error), 16'd1);
    tick(); check("err_zero_stay", 16'(betting), 16'd1);
    start = 1'b0;
    #1;
    check("err_clear", 16'(bet_error), 16'd0);
    check("err_balance", 16'(balance), 16'd100);

    // Whole balance lost: banker natural 9
    pscore = 4'd0; dscore = 4'd9;
    accept_and_deal(2'b01, 10'd100, 10'd0);
    tick(); tick(); check("broke_result", 16'(result), 16'd2);
    tick();
    check("broke_game_over", 16'(game_over), 16'd1);
    check("broke_betting", 16'(betting), 16'd0);
    check("broke_balance", 16'(balance), 16'd0);
    check("broke_rounds", 16'(rounds), 16'd2);
    bet_in = 2'b01; wager_in = 10'd1; start = 1'b1;
    #1;
    check("broke_no_accept", 16'(load_wager), 16'd0);
    check("broke_no_error", 16'(bet_error), 16'd0);
    tick(); tick();
    check("broke_hold", 16'(game_over), 16'd1);
    start = 1'b0;

    // Asynchronous reset in the middle of P2
    do_reset();
    bet_in = 2'b01; wager_in = 10'd10; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("mid_in_p2", 16'(load_pcard2), 16'd1);
    check("mid_debited", 16'(balance), 16'd90);
    resetb = 1'b0;
    #1;
    check("mid_rst_betting", 16'(betting), 16'd1);
    check("mid_rst_balance", 16'(balance), 16'd100);
    check("mid_rst_result", 16'(result), 16'd0);
    check("mid_rst_strobe", 16'(load_pcard2), 16'd0);
    check("mid_rst_rounds", 16'(rounds), 16'd0);
    #1 resetb = 1'b1;
    tick();
    check("mid_post_betting", 16'(betting), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
